moore_seq_controller: RTL and testbench
=======================================

# moore_seq_controller

Moore-style sequence-detector controller that computes next-state for a registered 3-bit state stage and sequences it from a serial input bit stream. It recognises the pattern 1011, with overlap allowed, and keeps a saturating count of detections. It sits in the exercise-1 Moore path as the control block around the state flip-flops, with its state register inside the block.

## Interface

Parameters:
- CNT_W, default 4: width of the detection counter; valid range 2..16.

Ports:
- inputClk  input  1  system clock, rising-edge active.
- inputR  input  1  reset, synchronous, active-high.
- inputX  input  1  serial data bit.
- inputEn  input  1  bit-valid qualifier; inputX is consumed only when high.
- inputClr  input  1  synchronous clear of the counter only; does not affect state.
- outputZ  output  1  Moore detect output; high while in state S4.
- outputState  output  3  current registered state encoding.
- outputCount  output  CNT_W  number of detections, saturating.
- outputSat  output  1  high when outputCount equals 2^CNT_W-1.

Reset is synchronous and active-high on inputR, sampled at the rising edge of inputClk, which is the block's only clock.

## Operation

- State encoding: S0=000 (no match), S1=001 ("1"), S2=010 ("10"), S3=011 ("101"), S4=100 ("1011" detected).
- Transitions are taken only on edges where inputEn=1. The entries below give the next state for inputX=0 / inputX=1:
  - S0: 0 -> S0, 1 -> S1.
  - S1: 0 -> S2, 1 -> S1.
  - S2: 0 -> S0, 1 -> S3.
  - S3: 0 -> S2, 1 -> S4.
  - S4: 0 -> S2, 1 -> S1. This gives overlap: a detect state followed by "011" detects again.
- inputEn=0: state holds, regardless of inputX.
- Illegal encodings 101, 110 and 111 go to S0 on the next edge, regardless of inputEn. outputZ is 0 in these states.
- outputZ = (state == S4). It is a function of state only, with no combinational path from inputX.
- Counter behaviour:
  - It increments by 1 on any edge where inputEn=1 and the next state is S4, provided it is below maximum.
  - At 2^CNT_W-1 it holds. There is no wrap-around.
- outputSat = (outputCount == 2^CNT_W-1), decoded from the registered count.
- Priority on each edge, highest first: inputR, then inputClr, then increment.
  - inputR=1: state <- S0, count <- 0.
  - inputClr=1 on the same edge as a detection: count <- 0, and the detection is not counted. The state still advances to S4 normally.

## Timing

- Reset values: outputState=000, outputZ=0, outputCount=0, outputSat=0. All are registered outputs, valid from the first edge after inputR is asserted.
- Latency: the 4th pattern bit, sampled at edge N, gives outputZ=1 and the incremented outputCount together after edge N, i.e. one-cycle latency.
- outputZ stays high for exactly one cycle when inputEn stays high. It stays high for multiple cycles if inputEn drops while in S4.
- Reset mid-pattern discards partial matches. The bit present on the reset edge is not consumed.
- inputClr affects outputCount only; it does not change state or outputZ.

## Test plan

- Reset then inputEn=1, inputX = 1,0,1,1,0,1,1 on consecutive edges -> outputZ high after the 4th and 7th edges only (overlap); outputCount=2.
- Same pattern with inputEn=0 inserted for 3 cycles between bits 2 and 3, with inputX toggling during the gap -> state holds at S2 through the gap; single detection; outputCount=1.
- CNT_W=2, feed 1011 five times -> outputCount goes 1,2,3,3,3; outputSat=1 from the third detection on; no wrap.
- Assert inputClr on the edge where the 4th bit of 1011 is sampled, with count=2 -> outputZ=1 and outputCount=0 after that edge.
- Feed 1,0,1 then assert inputR with inputX=1 -> outputState=000, outputCount=0, outputZ=0. The following 0,1,1 produces no detection; a fresh 1011 is then required to detect.
- Force the state register to 110 with inputEn=0 -> outputState=000 after one edge; outputZ stays 0 throughout.

Source files
------------

// File: rtl/moore_seq_controller.sv
// Moore detector for the serial pattern 1011 (overlap allowed) with a saturating
// detection counter. State register, next-state logic and counter live in this block.
module moore_seq_controller #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             inputClk,
    input  logic             inputR,
    input  logic             inputX,
    input  logic             inputEn,
    input  logic             inputClr,
    output logic             outputZ,
    output logic [2:0]       outputState,
    output logic [CNT_W-1:0] outputCount,
    output logic             outputSat
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    // Kept as a raw vector so the unused encodings 101/110/111 stay representable.
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             detect;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      if (inputEn) state_d = inputX ? S1 : S0;
            S1:      if (inputEn) state_d = inputX ? S1 : S2;
            S2:      if (inputEn) state_d = inputX ? S3 : S0;
            S3:      if (inputEn) state_d = inputX ? S4 : S2;
            S4:      if (inputEn) state_d = inputX ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    // Only an enabled edge landing in S4 counts; holding in S4 with inputEn low does not.
    assign detect = inputEn && (state_d == S4);

    always_comb begin
        count_d = count_q;
        if (inputClr) begin
            count_d = '0;
        end else if (detect && (count_q != CntMax)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge inputClk) begin
        if (inputR) begin
            state_q <= S0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign outputState = state_q;
    assign outputZ     = (state_q == S4);
    assign outputCount = count_q;
    assign outputSat   = (count_q == CntMax);

endmodule

// File: tb/tb_moore_seq_controller.sv
// Directed bench for moore_seq_controller: two instances (CNT_W=4 and CNT_W=2) share
// stimulus; expected values are hand-derived from the 1011 Moore state table.
module tb_moore_seq_controller;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
    logic       x   = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;

    logic       z4, sat4, z2, sat2;
    logic [2:0] st4, st2;
    logic [3:0] cnt4;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    moore_seq_controller #(.CNT_W(4)) dut (
        .inputClk    (clk),
        .inputR      (r),
        .inputX      (x),
        .inputEn     (en),
        .inputClr    (clr),
        .outputZ     (z4),
        .outputState (st4),
        .outputCount (cnt4),
        .outputSat   (sat4)
    );

    moore_seq_controller #(.CNT_W(2)) dut2 (
        .inputClk    (clk),
        .inputR      (r),
        .inputX      (x),
        .inputEn     (en),
        .inputClr    (clr),
        .outputZ     (z2),
        .outputState (st2),
        .outputCount (cnt2),
        .outputSat   (sat2)
    );

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive inputs at negedge, let one rising edge pass, then settle before sampling.
    task automatic step(input logic bx, input logic ben, input logic bclr, input logic br);
        @(negedge clk);
        x   = bx;
        en  = ben;
        clr = bclr;
        r   = br;
        @(posedge clk);
        #1;
        r   = 1'b0;
        clr = 1'b0;
    endtask

    task automatic expect4(input string tag, input int est, input int ez, input int ecnt);
        check({tag, " state"}, int'(st4), est);
        check({tag, " z"}, int'(z4), ez);
        check({tag, " count"}, int'(cnt4), ecnt);
    endtask

    logic [6:0] pat_a;
    int         st_a [7];
    int         z_a  [7];
    int         c_a  [7];

    initial begin
        // Reset state
        step(1'b1, 1'b1, 1'b0, 1'b1);
        expect4("reset", 0, 0, 0);
        check("reset sat", int'(sat4), 0);

        // 1,0,1,1,0,1,1 -> detections after edges 4 and 7 (overlap)
        pat_a = 7'b1011011;
        st_a  = '{1, 2, 3, 4, 2, 3, 4};
        z_a   = '{0, 0, 0, 1, 0, 0, 1};
        c_a   = '{0, 0, 0, 1, 1, 1, 2};
        for (int i = 0; i < 7; i++) begin
            step(pat_a[6-i], 1'b1, 1'b0, 1'b0);
            expect4($sformatf("overlap bit%0d", i + 1), st_a[i], z_a[i], c_a[i]);
        end

        // Enable gap between bits 2 and 3 with x toggling: state holds in S2
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("gap pre state", int'(st4), 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("gap hold1", int'(st4), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap hold2", int'(st4), 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("gap hold3", int'(st4), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect4("gap bit3", 3, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect4("gap detect", 4, 1, 1);

        // Z held over several cycles when enable drops in S4; no extra counting
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect4("s4 hold", 4, 1, 1);

        // Second detection via overlap 0,1,1 -> count 2
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect4("pre clr detect", 4, 1, 2);

        // Clear on the detecting edge: state still reaches S4, count goes to 0
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        expect4("clr on detect", 4, 1, 0);

        // Clear alone leaves state alone
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        expect4("clr state kept", 3, 0, 0);

        // Reset mid-pattern discards 101 and does not consume the bit on the reset edge
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre reset state", int'(st4), 3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        expect4("mid reset", 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect4("after reset 011", 1, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect4("fresh 1011", 4, 1, 1);

        // Illegal encoding 110 with enable low recovers to S0 in one edge
        @(negedge clk);
        en = 1'b0;
        x  = 1'b1;
        force dut.state_q = 3'b110;
        #1;
        check("illegal 110 state", int'(st4), 6);
        check("illegal 110 z", int'(z4), 0);
        release dut.state_q;
        @(posedge clk);
        #1;
        check("illegal 110 recover", int'(st4), 0);
        check("illegal 110 z after", int'(z4), 0);

        // Illegal 111 with enable high and x=1 still goes to S0, not S1
        @(negedge clk);
        en = 1'b1;
        x  = 1'b1;
        force dut.state_q = 3'b111;
        #1;
        check("illegal 111 z", int'(z4), 0);
        release dut.state_q;
        @(posedge clk);
        #1;
        check("illegal 111 recover", int'(st4), 0);

        // Saturation: five 1011 sequences; CNT_W=2 saturates at 3, CNT_W=4 reaches 5
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("sat reset cnt2", int'(cnt2), 0);
        check("sat reset sat2", int'(sat2), 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("sat det%0d cnt2", k + 1), int'(cnt2), (k < 3) ? k + 1 : 3);
            check($sformatf("sat det%0d sat2", k + 1), int'(sat2), (k >= 2) ? 1 : 0);
            check($sformatf("sat det%0d z2", k + 1), int'(z2), 1);
        end
        check("cnt4 five detects", int'(cnt4), 5);
        check("sat4 low", int'(sat4), 0);

        // Clear on saturated narrow counter
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clr sat cnt2", int'(cnt2), 0);
        check("clr sat sat2", int'(sat2), 0);
        check("clr keeps state", int'(st2), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
